// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and legal stop-bit range shared by the UART receive path
package uart_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_CLEANUP = 3'd5
  } rx_state_t;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;
  function automatic int legal_stop_bits(input int n);
    return (n >= STOP_BITS_MIN && n <= STOP_BITS_MAX) ? n : STOP_BITS_MIN;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word fall-through synchronous FIFO; a pop frees room for a same-cycle push when full
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_en);
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign rd_data = empty ? '0 : mem[rd_ptr];
  // storage write, no reset needed since the head is masked while empty
  always_ff @(posedge i_Clock)
    if (wr_ok) mem[wr_ptr] <= wr_data;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge i_Clock)
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_ok);
      rd_ptr <= rd_ptr + AW'(rd_ok);
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: UART receiver feeding a FWFT FIFO with sticky errors; UART_RX_PARITY_EN adds a parity bit
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 8
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Rx_Serial,
  input  logic                          i_Read_Flag,
  input  logic                          i_Clear_Err,
  output logic [DATA_BITS-1:0]          o_Rx_Byte,
  output logic                          o_Rx_DV,
  output logic                          o_Empty,
  output logic                          o_Full,
  output logic [$clog2(FIFO_DEPTH):0]   o_Count,
  output logic                          o_Frame_Err,
  output logic                          o_Overrun,
`ifdef UART_RX_PARITY_EN
  output logic                          o_Parity_Err,
`endif
  output logic [2:0]                    o_SM_State
);
  localparam int NSTOP = legal_stop_bits(STOP_BITS);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] MID = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0] DB_LAST = 3'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(NSTOP - 1);
  rx_state_t state;
  logic [7:0] clk_cnt;
  logic [2:0] bit_idx;
  logic stop_idx, stop_bad, rx_dv;
  logic [DATA_BITS-1:0] data_sr;
  logic rx_meta, rx_sync, armed;
  logic [1:0] sync_vld;
  logic tick, cleanup, par_ok, frame_ev, overrun_ev;
  assign tick = clk_cnt == LAST;
  assign cleanup = state == S_CLEANUP;
  assign o_Rx_DV = rx_dv;
  assign o_SM_State = state;
`ifdef UART_RX_PARITY_EN
  logic par_bit, parity_ev;
  assign par_ok = (^data_sr ^ par_bit) == PARITY_ODD;
  assign parity_ev = cleanup & ~par_ok;
`else
  assign par_ok = 1'b1;
`endif
  assign frame_ev = cleanup & stop_bad;
  assign overrun_ev = rx_dv & o_Full & ~i_Read_Flag;
  // the reset value of the synchroniser is not a real line sample, so arming waits until it has flushed
  always_ff @(posedge i_Clock)
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      sync_vld <= 2'b00;
      armed <= 1'b0;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_sync <= rx_meta;
      sync_vld <= {sync_vld[0], 1'b1};
      armed <= armed | (sync_vld[1] & rx_sync);
    end
  // receiver FSM; rx_dv is registered so it is high exactly during CLEANUP
  always_ff @(posedge i_Clock)
    if (i_Reset) begin
      state <= S_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      stop_idx <= 1'b0;
      stop_bad <= 1'b0;
      data_sr <= '0;
      rx_dv <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      rx_dv <= 1'b0;
      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          stop_idx <= 1'b0;
          stop_bad <= 1'b0;
          if (!rx_sync && armed) state <= S_START;
        end
        S_START:
          if (clk_cnt == MID) begin
            clk_cnt <= '0;
            state <= rx_sync ? S_IDLE : S_DATA;
          end else clk_cnt <= clk_cnt + 8'd1;
        S_DATA:
          if (tick) begin
            clk_cnt <= '0;
            data_sr <= {rx_sync, data_sr[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == DB_LAST) begin
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else clk_cnt <= clk_cnt + 8'd1;
`ifdef UART_RX_PARITY_EN
        S_PARITY:
          if (tick) begin
            clk_cnt <= '0;
            par_bit <= rx_sync;
            state <= S_STOP;
          end else clk_cnt <= clk_cnt + 8'd1;
`endif
        S_STOP:
          if (tick) begin
            clk_cnt <= '0;
            stop_bad <= stop_bad | ~rx_sync;
            stop_idx <= stop_idx + 1'b1;
            if (stop_idx == STOP_LAST) begin
              state <= S_CLEANUP;
              rx_dv <= ~stop_bad & rx_sync & par_ok;
            end
          end else clk_cnt <= clk_cnt + 8'd1;
        S_CLEANUP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  // sticky error flags; a same-cycle event beats the clear
  always_ff @(posedge i_Clock)
    if (i_Reset) begin
      o_Frame_Err <= 1'b0;
      o_Overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_Parity_Err <= 1'b0;
`endif
    end else begin
      o_Frame_Err <= (o_Frame_Err & ~i_Clear_Err) | frame_ev;
      o_Overrun <= (o_Overrun & ~i_Clear_Err) | overrun_ev;
`ifdef UART_RX_PARITY_EN
      o_Parity_Err <= (o_Parity_Err & ~i_Clear_Err) | parity_ev;
`endif
    end
  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .wr_en   (rx_dv),
    .wr_data (data_sr),
    .rd_en   (i_Read_Flag),
    .rd_data (o_Rx_Byte),
    .empty   (o_Empty),
    .full    (o_Full),
    .count   (o_Count)
  );
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: randomized frames against a queue model, monitor checks reads and DV pulses
module tb_uart_rx_buffered;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rd = 1'b0, clr = 1'b0;
  logic [7:0] rx_byte;
  logic dv, empty, full, ferr, ovr;
  logic [2:0] count, st;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  bit dv_q[$];
  bit exp_ferr = 0, exp_ovr = 0, pop_in_cleanup = 0;
  always #5 clk = ~clk;
  uart_rx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx), .i_Read_Flag(rd), .i_Clear_Err(clr),
    .o_Rx_Byte(rx_byte), .o_Rx_DV(dv), .o_Empty(empty), .o_Full(full), .o_Count(count),
    .o_Frame_Err(ferr), .o_Overrun(ovr), .o_SM_State(st)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // monitor: every DV must match a queued good frame, every read must match the model head
  always @(negedge clk)
    if (!rst) begin
      if (dv) begin
        chk("dv_expected", int'(dv_q.size() > 0), 1);
        if (dv_q.size() > 0) void'(dv_q.pop_front());
        chk("dv_in_cleanup", st, 5);
      end
      if (rd) begin
        chk("empty_on_read", empty, int'(exp_q.size() == 0));
        if (exp_q.size() > 0) chk("head", rx_byte, exp_q.pop_front());
      end
    end
  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    dv_q.delete();
    exp_ferr = 0;
    exp_ovr = 0;
    repeat (3) tick();
    rst = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop_ok;
    repeat (CPB) tick();
    rx = 1'b1;
    if (stop_ok) begin
      dv_q.push_back(1'b1);
      if (exp_q.size() < DEPTH || pop_in_cleanup) exp_q.push_back(b);
      else exp_ovr = 1;
    end else exp_ferr = 1;
    repeat (4) tick();
  endtask
  task automatic read_n(input int n);
    repeat (n) begin
      rd = 1'b1;
      tick();
      rd = 1'b0;
    end
  endtask
  task automatic clear_err();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_ferr = 0;
    exp_ovr = 0;
  endtask
  task automatic check_status(input string tag);
    chk({tag, "_count"}, count, exp_q.size());
    chk({tag, "_empty"}, empty, int'(exp_q.size() == 0));
    chk({tag, "_full"}, full, int'(exp_q.size() == DEPTH));
    chk({tag, "_ferr"}, ferr, exp_ferr);
    chk({tag, "_ovr"}, ovr, exp_ovr);
    chk({tag, "_idle"}, st, 0);
  endtask
  task automatic pop_at_cleanup();
    int n = 0;
    while (st != 3'd5 && n < 200) begin
      tick();
      n++;
    end
    chk("cleanup_seen", int'(n < 200), 1);
    if (n < 200) begin
      rd = 1'b1;
      tick();
      rd = 1'b0;
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    int bad;
    logic [7:0] b;
    do_reset();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dv", dv, 0);
    chk("rst_byte", rx_byte, 0);
    chk("rst_count", count, 0);
    chk("rst_state", st, 0);
    chk("rst_flags", {ferr, ovr}, 0);
    repeat (4) tick();
    send_frame(8'hA5, 1);
    check_status("a5");
    chk("a5_head", rx_byte, 8'hA5);
    read_n(1);
    check_status("a5_read");
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1);
    check_status("five");
    chk("five_ovr", ovr, 1);
    clear_err();
    check_status("five_clr");
    read_n(4);
    check_status("five_drain");
    read_n(2);
    check_status("empty_read");
    send_frame(8'h11, 1);
    send_frame(8'h3C, 0);
    check_status("badstop");
    chk("badstop_ferr", ferr, 1);
    clear_err();
    read_n(1);
    check_status("badstop_drain");
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (12) tick();
    check_status("glitch");
    rx = 1'b0;
    repeat (3 * CPB) tick();
    chk("mid_frame_data", st, 2);
    do_reset();
    bad = 0;
    repeat (60) begin
      tick();
      if (st != 3'd0) bad++;
    end
    chk("disarmed_idle", bad, 0);
    check_status("disarmed");
    rx = 1'b1;
    repeat (4) tick();
    send_frame(8'h5A, 1);
    check_status("rearmed");
    read_n(1);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom_range(0, 255)), 1);
    check_status("prefill");
    pop_in_cleanup = 1;
    fork
      send_frame(8'hC3, 1);
      pop_at_cleanup();
    join
    pop_in_cleanup = 0;
    check_status("full_pop");
    chk("full_pop_count", count, 4);
    read_n(4);
    check_status("full_pop_drain");
    for (int k = 0; k < 30; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, $urandom_range(0, 4) != 0);
      check_status("rand");
      if ($urandom_range(0, 2) == 0) read_n($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) clear_err();
    end
    read_n(exp_q.size());
    repeat (10) tick();
    check_status("final");
    chk("dv_pending", dv_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
